// File: rtl/axil_regbank_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the register bank.
package axil_regbank_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_slave_regbank_if.sv
// AXI4-Lite bus bundle between the master IP and the register bank slave.
interface axil_slave_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_regbank_store.sv
// Register array with byte-strobed write port, per-register write pulse and combinational read mux.
// Range flags exist only when AXIL_REGBANK_SLVERR_EN is defined.
module axil_regbank_store #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rd_data,
`ifdef AXIL_REGBANK_SLVERR_EN
  output logic                       wr_hit,
  output logic                       rd_hit,
`endif
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  // Out-of-range indices match no entry, so such writes fall away naturally.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_sel[k] = wr_en && (wr_idx == IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_sel;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_sel[k]) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_strb[b]) regs_q[k][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k)) rd_data = regs_q[k];
    end
  end

`ifdef AXIL_REGBANK_SLVERR_EN
  assign wr_hit = int'(wr_idx) < NUM_REGS;
  assign rd_hit = int'(rd_idx) < NUM_REGS;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: rtl/axil_slave_regbank.sv
// AXI4-Lite slave register bank; AXIL_REGBANK_SLVERR_EN makes out-of-range accesses return SLVERR.
// Latency: BVALID one cycle after the later of AW/W handshakes; RVALID one cycle after AR.
// Backpressure: AW/W/AR READY drop while a channel is held or a response awaits B/RREADY.
module axil_slave_regbank
  import axil_regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  axil_slave_regbank_if.slave        s_axi,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]        o_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;

  wr_state_t           wr_state, wr_state_n;
  logic                aw_have, aw_have_n, w_have, w_have_n;
  logic                awready_q, awready_n, wready_q, wready_n;
  logic                bvalid_q, bvalid_n;
  logic [1:0]          bresp_q, bresp_n;
  logic [IDX_W-1:0]    aw_idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  rd_state_t           rd_state, rd_state_n;
  logic                arready_q, arready_n, rvalid_q, rvalid_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic [1:0]          rresp_q, rresp_n;

  logic                aw_hs, w_hs, ar_hs, wr_fire;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [DATA_W-1:0]   wr_data, rd_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [1:0]          wr_resp, rd_resp;

  assign aw_hs = s_axi.awvalid && awready_q;
  assign w_hs  = s_axi.wvalid  && wready_q;
  assign ar_hs = s_axi.arvalid && arready_q;

  // A channel that arrived earlier is replayed from its holding register.
  assign wr_idx  = aw_have ? aw_idx_q : s_axi.awaddr[ADDR_W-1:2];
  assign wr_data = w_have  ? wdata_q  : s_axi.wdata;
  assign wr_strb = w_have  ? wstrb_q  : s_axi.wstrb;
  assign wr_fire = (wr_state == WR_IDLE) && (aw_have || aw_hs) && (w_have || w_hs);
  assign rd_idx  = s_axi.araddr[ADDR_W-1:2];

`ifdef AXIL_REGBANK_SLVERR_EN
  logic wr_hit, rd_hit;
  assign wr_resp = wr_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
  assign rd_resp = rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`else
  assign wr_resp = AXI_RESP_OKAY;
  assign rd_resp = AXI_RESP_OKAY;
`endif

  axil_regbank_store #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_store (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .wr_en     (wr_fire),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
`ifdef AXIL_REGBANK_SLVERR_EN
    .wr_hit    (wr_hit),
    .rd_hit    (rd_hit),
`endif
    .regs_flat (o_regs),
    .wr_pulse  (o_wr_pulse)
  );

  always_comb begin
    wr_state_n = wr_state;
    aw_have_n  = aw_have || aw_hs;
    w_have_n   = w_have || w_hs;
    awready_n  = awready_q;
    wready_n   = wready_q;
    bvalid_n   = bvalid_q;
    bresp_n    = bresp_q;
    case (wr_state)
      WR_IDLE: begin
        if (wr_fire) begin
          wr_state_n = WR_RESP;
          aw_have_n  = 1'b0;
          w_have_n   = 1'b0;
          awready_n  = 1'b0;
          wready_n   = 1'b0;
          bvalid_n   = 1'b1;
          bresp_n    = wr_resp;
        end else begin
          awready_n = !(aw_have || aw_hs);
          wready_n  = !(w_have || w_hs);
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          wr_state_n = WR_IDLE;
          bvalid_n   = 1'b0;
          awready_n  = 1'b1;
          wready_n   = 1'b1;
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    arready_n  = arready_q;
    rvalid_n   = rvalid_q;
    rdata_n    = rdata_q;
    rresp_n    = rresp_q;
    case (rd_state)
      RD_IDLE: begin
        arready_n = 1'b1;
        if (ar_hs) begin
          rd_state_n = RD_DATA;
          arready_n  = 1'b0;
          rvalid_n   = 1'b1;
          rdata_n    = rd_data;
          rresp_n    = rd_resp;
        end
      end
      RD_DATA: begin
        if (s_axi.rready) begin
          rd_state_n = RD_IDLE;
          rvalid_n   = 1'b0;
          arready_n  = 1'b1;
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state  <= WR_IDLE;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rd_state  <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
    end else begin
      wr_state  <= wr_state_n;
      aw_have   <= aw_have_n;
      w_have    <= w_have_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      if (aw_hs) aw_idx_q <= s_axi.awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      rd_state  <= rd_state_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
